pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, 255, max consecutive wait cycles before memory-timeout error (range 1..255).
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising clk only.
REQ-004 Rd_ex  input  5  destination register of instruction in EX.
REQ-005 MemtoReg_ex  input  1  EX instruction is a load.
REQ-006 Rn_id, Rm_id  input  5 each  source registers of instruction in ID.
REQ-007 uses_rm_id  input  1  ID instruction reads Rm.
REQ-008 br_taken_mem  input  1  branch/CBZ/BR resolved taken in MEM.
REQ-009 mem_req_mem  input  1  MEM instruction accesses data memory.
REQ-010 mem_ack  input  1  data memory completes access this cycle.
REQ-011 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  load enables for PC and pipeline registers.
REQ-012 if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  load a bubble (all control fields zero) on next edge.
REQ-013 mem_err  output  1  sticky memory-timeout flag.

Function
REQ-014 FSM states RUN, MEM_WAIT, ERR; enables/flushes are combinational from state and inputs; state, wait counter, mem_err registered.
REQ-015 RUN default: all enables 1, all flushes 0.
REQ-016 Load-use hazard (RUN): MemtoReg_ex=1, Rd_ex!=31, and Rd_ex==Rn_id or (uses_rm_id=1 and Rd_ex==Rm_id) -> pc_en=0, if_id_en=0, id_ex_flush=1, others 1; one-cycle stall.
REQ-017 Register 31 (XZR) never creates a hazard.
REQ-018 Branch taken (RUN, br_taken_mem=1): if_id_flush, id_ex_flush, ex_mem_flush=1, all enables 1; overrides load-use in same cycle.
REQ-019 Memory stall: in RUN, mem_req_mem=1 and mem_ack=0 -> next state MEM_WAIT; all enables 0, flushes 0 this cycle; overrides branch and load-use.
REQ-020 mem_req_mem=1 with mem_ack=1 in RUN: no stall, normal RUN rules apply.
REQ-021 MEM_WAIT: all enables 0, flushes 0; 8-bit wait counter increments each cycle, starting at 1 on entry.
REQ-022 MEM_WAIT with mem_ack=1: outputs follow RUN rules (including branch flush and load-use) that cycle; next state RUN; counter cleared.
REQ-023 MEM_WAIT with counter==MEM_TIMEOUT and mem_ack=0: next state ERR, mem_err set; mem_ack in the same cycle wins over timeout.
REQ-024 ERR: all enables 0, flushes 0, mem_err=1; exits only via reset.
REQ-025 Counter saturates, never wraps.

Reset
REQ-026 reset=0 at rising edge: state RUN, wait counter 0, mem_err 0, performance counters 0.
REQ-027 While reset=0: all enables 0, all flushes 0, regardless of other inputs.
REQ-028 Reset mid-MEM_WAIT or in ERR returns to RUN on that edge; first cycle after reset release follows RUN rules.

Configuration
REQ-029 Macro PIPE_CTRL_PERF_EN: when defined, outputs stall_cnt[31:0] (cycles with pc_en=0 while reset=1) and flush_cnt[31:0] (cycles with if_id_flush=1), both saturating at 0xFFFFFFFF, cleared by reset.
REQ-030 Without PIPE_CTRL_PERF_EN: those ports and counters are absent; all other behaviour identical.

Verification
REQ-031 Load-use: MemtoReg_ex=1, Rd_ex=5, Rn_id=5 -> pc_en=0, if_id_en=0, id_ex_flush=1 for exactly that cycle.
REQ-032 XZR: MemtoReg_ex=1, Rd_ex=31, Rn_id=31 -> no stall, all enables 1.
REQ-033 Branch + load-use same cycle: br_taken_mem=1 with REQ-031 hazard -> three flushes 1, all enables 1.
REQ-034 Memory wait: mem_req_mem=1, mem_ack low 3 cycles then high -> enables 0 for 3 cycles, 1 on ack cycle, state RUN after.
REQ-035 Timeout: MEM_TIMEOUT=4, mem_ack held 0 -> mem_err=1 after 4 wait cycles, enables stay 0 until reset=0 clears to RUN.
REQ-036 With PIPE_CTRL_PERF_EN: REQ-034 sequence -> stall_cnt=3; one branch flush -> flush_cnt=1.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use stall, taken-branch flush, memory wait and timeout.
// Optional performance counters (stall_cnt, flush_cnt) are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rd_ex,
    input  logic        MemtoReg_ex,
    input  logic [4:0]  Rn_id,
    input  logic [4:0]  Rm_id,
    input  logic        uses_rm_id,
    input  logic        br_taken_mem,
    input  logic        mem_req_mem,
    input  logic        mem_ack,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic        mem_err
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       load_use;
    logic       run_rules;
    logic       mem_stall;

    assign load_use  = MemtoReg_ex && (Rd_ex != 5'd31) &&
                       ((Rd_ex == Rn_id) || (uses_rm_id && (Rd_ex == Rm_id)));
    assign mem_stall = mem_req_mem && !mem_ack;

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        run_rules    = 1'b0;
        if (reset) begin
            unique case (state)
                RUN:      run_rules = !mem_stall;
                MEM_WAIT: run_rules = mem_ack;
                default:  run_rules = 1'b0;
            endcase
        end
        if (run_rules) begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            // Taken branch discards the wrong-path instructions, which makes any load-use moot.
            if (br_taken_mem) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
`ifdef PIPE_CTRL_PERF_EN
            stall_cnt <= '0;
            flush_cnt <= '0;
`endif
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == TIMEOUT) begin
                        state   <= ERR;
                        mem_err <= 1'b1;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= ERR;
                    mem_err <= 1'b1;
                end
            endcase
`ifdef PIPE_CTRL_PERF_EN
            if (!pc_en && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
            if (if_id_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 32'd1;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed hazard/branch/wait/timeout sequences then random traffic.
// Expected outputs come from a cycle-level reference model of the controller rules.
module tb_pipe_ctrl;

    localparam int unsigned TO = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rd_ex, Rn_id, Rm_id;
    logic        MemtoReg_ex, uses_rm_id, br_taken_mem, mem_req_mem, mem_ack;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    pipe_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .Rd_ex(Rd_ex), .MemtoReg_ex(MemtoReg_ex), .Rn_id(Rn_id), .Rm_id(Rm_id),
        .uses_rm_id(uses_rm_id), .br_taken_mem(br_taken_mem),
        .mem_req_mem(mem_req_mem), .mem_ack(mem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  outs;
        logic        err;
        logic [31:0] st;
        logic [31:0] fl;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;

    // Reference model: "waiting" with a 1-based wait-cycle index, and a dead (timed-out) flag.
    bit          m_waiting = 1'b0;
    int unsigned m_waited  = 0;
    bit          m_dead    = 1'b0;
    int unsigned m_st = 0, m_fl = 0;

    function automatic logic [7:0] ref_outs();
        bit hz;
        // order: pc, if_id, id_ex, ex_mem, mem_wb enables; if_id, id_ex, ex_mem flushes
        if (!reset || m_dead) return 8'b00000_000;
        if (!m_waiting && mem_req_mem && !mem_ack) return 8'b00000_000;
        if (m_waiting && !mem_ack) return 8'b00000_000;
        if (br_taken_mem) return 8'b11111_111;
        hz = MemtoReg_ex && Rd_ex != 31 &&
             (Rd_ex == Rn_id || (uses_rm_id && Rd_ex == Rm_id));
        if (hz) return 8'b00111_010;
        return 8'b11111_000;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(string tag, bit rst, int rd, bit m2r, int rn, int rm, bit urm,
                        bit br, bit req, bit ack);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; Rd_ex = 5'(rd); MemtoReg_ex = m2r; Rn_id = 5'(rn); Rm_id = 5'(rm);
        uses_rm_id = urm; br_taken_mem = br; mem_req_mem = req; mem_ack = ack;
        #0;
        e.outs = ref_outs();
        e.err  = m_dead;
        e.st   = m_st;
        e.fl   = m_fl;
        e.tag  = tag;
        q.push_back(e);
        mon_on = 1'b1;
        if (!rst) begin
            m_waiting = 1'b0; m_waited = 0; m_dead = 1'b0; m_st = 0; m_fl = 0;
        end else begin
            if (!e.outs[7]) m_st++;
            if (e.outs[2]) m_fl++;
            if (!m_dead) begin
                if (m_waiting) begin
                    if (ack) m_waiting = 1'b0;
                    else if (m_waited == TO) begin m_dead = 1'b1; m_waiting = 1'b0; end
                    else m_waited++;
                end else if (req && !ack) begin
                    m_waiting = 1'b1; m_waited = 1;
                end
            end
        end
    endtask

    task automatic idle(string tag, bit rst);
        step(tag, rst, 0, 0, 1, 2, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.tag, "_outs"}, 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                                           if_id_flush, id_ex_flush, ex_mem_flush}), 32'(e.outs));
                chk({e.tag, "_mem_err"}, 32'(mem_err), 32'(e.err));
`ifdef PIPE_CTRL_PERF_EN
                chk({e.tag, "_stall_cnt"}, stall_cnt, e.st);
                chk({e.tag, "_flush_cnt"}, flush_cnt, e.fl);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; Rd_ex = '0; MemtoReg_ex = 1'b0; Rn_id = '0; Rm_id = '0;
        uses_rm_id = 1'b0; br_taken_mem = 1'b0; mem_req_mem = 1'b0; mem_ack = 1'b0;

        // reset held with active-looking inputs: everything must stay off
        step("rst_hold", 0, 5, 1, 5, 5, 1, 1, 1, 0);
        step("rst_hold", 0, 3, 0, 1, 2, 0, 1, 0, 0);
        idle("rst_idle", 0);
        idle("run_default", 1);

        step("load_use", 1, 5, 1, 5, 0, 0, 0, 0, 0);
        idle("after_load_use", 1);
        step("load_use_rm", 1, 7, 1, 1, 7, 1, 0, 0, 0);
        step("rm_unused", 1, 7, 1, 1, 7, 0, 0, 0, 0);
        step("xzr", 1, 31, 1, 31, 31, 1, 0, 0, 0);
        step("br_and_hazard", 1, 5, 1, 5, 0, 0, 1, 0, 0);
        step("req_acked", 1, 5, 1, 5, 0, 0, 0, 1, 1);

        idle("perf_clear", 0);
        step("wait0", 1, 0, 0, 1, 2, 0, 0, 1, 0);
        step("wait1", 1, 0, 0, 1, 2, 0, 0, 1, 0);
        step("wait2", 1, 0, 0, 1, 2, 0, 0, 1, 0);
        step("wait_ack", 1, 0, 0, 1, 2, 0, 0, 1, 1);
        idle("after_wait", 1);
        step("one_branch", 1, 0, 0, 1, 2, 0, 1, 0, 0);
        idle("after_branch", 1);

        step("ack_with_br", 1, 0, 0, 1, 2, 0, 0, 1, 0);
        step("ack_with_br", 1, 4, 1, 4, 0, 0, 1, 1, 1);
        step("ack_with_hz", 1, 0, 0, 1, 2, 0, 0, 1, 0);
        step("ack_with_hz", 1, 4, 1, 4, 0, 0, 0, 1, 1);

        for (int unsigned i = 0; i < TO + 4; i++)
            step("timeout", 1, 0, 0, 1, 2, 0, 1, 1, 0);
        step("err_ack_ignored", 1, 0, 0, 1, 2, 0, 0, 1, 1);
        idle("err_reset", 0);
        idle("after_err", 1);

        // ack on exactly the timeout cycle must win
        for (int unsigned i = 0; i < TO; i++)
            step("ack_at_limit", 1, 0, 0, 1, 2, 0, 0, 1, 0);
        step("ack_at_limit", 1, 0, 0, 1, 2, 0, 0, 1, 1);
        idle("after_limit", 1);

        step("reset_mid_wait", 1, 0, 0, 1, 2, 0, 0, 1, 0);
        step("reset_mid_wait", 1, 0, 0, 1, 2, 0, 0, 1, 0);
        idle("reset_mid_wait", 0);
        idle("after_mid_reset", 1);

        for (int i = 0; i < 3000; i++) begin
            int rd, rn, rm;
            rd = ($urandom_range(0, 5) == 0) ? 31 : int'($urandom_range(0, 7));
            rn = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 7));
            rm = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 7));
            step("random", $urandom_range(0, 149) != 0, rd, 1'($urandom), rn, rm,
                 1'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) != 0);
        end

        @(negedge clk);
        #1;
        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
